pwm_gen_mc: RTL and testbench
=============================

Name: pwm_gen_mc

Overview:
- Multi-channel PWM generator and parametrised successor of the single-channel PWM block.
- One shared period counter drives CH independent compare channels, each with its own mode and polarity.
- Configuration is double-buffered: values written by the register file while running take effect only at the period wrap, so no output glitches.
- Sits between the register file (config strobes) and the pad/mux layer (pwm_out bus).

Parameters:
- CH, 4, number of PWM channels (1..16).
- W, 16, counter/compare width in bits (4..32).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  global enable; 0 holds counter at 0 and all outputs at inactive level.
- period_in  in  W  period value; counter counts 0..period inclusive.
- cmp1_in  in  CH*W  per-channel compare1; channel i at [i*W +: W].
- cmp2_in  in  CH*W  per-channel compare2.
- mode_in  in  CH*2  per-channel mode.
- pol_in  in  CH  per-channel polarity; 1 = invert output.
- ch_en_in  in  CH  per-channel enable.
- load  in  1  one-cycle strobe; captures all *_in values.
- cnt  out  W  current counter value.
- period_tick  out  1  one-cycle pulse on the cycle cnt becomes 0 by wrap.
- load_pending  out  1  shadow holds values not yet applied.
- pwm_out  out  CH  PWM outputs, registered.

Behaviour:
- State: shadow set (S) and active set (A) of period/cmp1/cmp2/mode/pol/ch_en; pending flag.
- Reset (rst_n=0 at clk edge), all registers to 0:
  - A and S cleared (ch_en=0, pol=0), pending=0.
  - cnt=0, period_tick=0, load_pending=0, pwm_out=0.
- Counter:
  - en=0: cnt<=0, period_tick<=0.
  - en=1, cnt>=A.period: cnt<=0, period_tick<=1 (wrap).
  - Otherwise: cnt<=cnt+1, period_tick<=0.
  - A.period=0 with en=1: wraps every cycle, period_tick held 1.
- Load:
  - load=1 with en=0: *_in copied directly to A and S the next cycle; pending<=0.
  - load=1 with en=1: *_in copied to S; pending<=1.
  - On a wrap cycle with pending=1: S copied to A; pending<=0. The new A applies from cnt=0 of the new period.
  - load=1 in the same cycle as a wrap:
    - Wrap applies the previous S if pending was set.
    - The new values go to S and pending<=1; they apply at the following wrap.
  - Repeated loads before a wrap: the last one wins.
- Output, per channel i, registered on the same edge as cnt:
  - raw is computed from n = next cnt value and A.
  - Modes:
    - 00 left-align: raw = (cmp1!=0) && (n<=cmp1).
    - 01 right-align: raw = (n>=cmp1).
    - 10 window: raw = (cmp1<cmp2) && (n>=cmp1) && (n<cmp2); cmp1>=cmp2 gives constant 0.
    - 11 reserved: raw = 0.
  - pwm_out[i] <= (en && A.ch_en[i]) ? raw ^ A.pol[i] : A.pol[i].
  - pwm_out[i] therefore always corresponds to the cnt value visible in the same cycle.
- Compare values greater than period are legal:
  - left-align is then 100% duty;
  - right-align is then 0% (never reached).
- All arithmetic is unsigned W-bit.
  - cnt+1 cannot overflow: wrap at cnt>=period happens first, including period=2^W-1.
- Channels are fully independent; CH=1 must elaborate cleanly.
- en deasserted mid-period:
  - next cycle cnt=0 and outputs go to their inactive levels;
  - pending is retained and applied at the first wrap after re-enable.
- Reset asserted mid-operation overrides load and en in that cycle.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles with en=1 and load=1 → cnt=0, pwm_out=0, load_pending=0. Release with en=0 → all stay 0.
- Left-align: W=16, CH=4; load period=9, ch0 mode00 cmp1=3 ch_en=1 (en=0), then en=1 → ch0 high for cnt 0..3 and low for 4..9 each period. period_tick pulses every 10 cycles. cmp1=0 → ch0 constant 0.
- Right-align, window, polarity:
  - ch1 mode01 cmp1=6 → high for cnt 6..9.
  - ch2 mode10 cmp1=2 cmp2=5 → high for cnt 2..4.
  - ch2 cmp1=5 cmp2=5 → constant 0.
  - ch3 pol=1 ch_en=0 → constant 1.
- Shadowed update: running with period=9; at cnt=4 load ch0 cmp1=7 → load_pending=1. Current period keeps cmp1=3. At wrap, load_pending=0 and ch0 is high for cnt 0..7.
- Load on wrap cycle: assert load exactly when cnt goes 9→0 → new values are not applied that wrap. load_pending stays 1 and values apply at the next wrap.
- Boundaries:
  - period=0 → cnt stuck at 0, period_tick=1 continuously.
  - period=16'hFFFF → cnt reaches FFFF, wraps to 0 without overflow.
  - en dropped at cnt=5 → next cycle cnt=0, pwm_out equals pol.

Source files
------------

// File: rtl/pwm_gen_mc_if.sv
// Configuration/status bundle between the register file (master) and
// the multi-channel PWM generator (slave).
interface pwm_gen_mc_if #(
  parameter int unsigned CH = 4,
  parameter int unsigned W  = 16
);
  logic            en;
  logic [W-1:0]    period_in;
  logic [CH*W-1:0] cmp1_in;
  logic [CH*W-1:0] cmp2_in;
  logic [CH*2-1:0] mode_in;
  logic [CH-1:0]   pol_in;
  logic [CH-1:0]   ch_en_in;
  logic            load;
  logic [W-1:0]    cnt;
  logic            period_tick;
  logic            load_pending;
  logic [CH-1:0]   pwm_out;

  modport master (
    output en, period_in, cmp1_in, cmp2_in, mode_in, pol_in, ch_en_in, load,
    input  cnt, period_tick, load_pending, pwm_out
  );

  modport slave (
    input  en, period_in, cmp1_in, cmp2_in, mode_in, pol_in, ch_en_in, load,
    output cnt, period_tick, load_pending, pwm_out
  );
endinterface

// File: rtl/pwm_gen_mc.sv
// Multi-channel PWM generator: one shared period counter, CH compare channels,
// double-buffered configuration that is applied only at the period wrap.
module pwm_gen_mc #(
  parameter int unsigned CH = 4,
  parameter int unsigned W  = 16
) (
  input logic         clk,
  input logic         rst_n,
  pwm_gen_mc_if.slave bus
);

  typedef struct packed {
    logic [W-1:0]    period;
    logic [CH*W-1:0] cmp1;
    logic [CH*W-1:0] cmp2;
    logic [CH*2-1:0] mode;
    logic [CH-1:0]   pol;
    logic [CH-1:0]   ch_en;
  } cfg_t;

  typedef enum logic [1:0] {
    MODE_LEFT  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_WIN   = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  cfg_t          cfg_in;
  cfg_t          act_q, act_d;
  cfg_t          shd_q, shd_d;
  logic          pend_q, pend_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic [CH-1:0] pwm_q, pwm_d;
  logic          wrap;

  always_comb begin
    cfg_in.period = bus.period_in;
    cfg_in.cmp1   = bus.cmp1_in;
    cfg_in.cmp2   = bus.cmp2_in;
    cfg_in.mode   = bus.mode_in;
    cfg_in.pol    = bus.pol_in;
    cfg_in.ch_en  = bus.ch_en_in;
  end

  // Wrap is checked before incrementing, so cnt+1 never overflows even at period=all-ones.
  assign wrap = bus.en && (cnt_q >= act_q.period);

  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (bus.en) begin
      if (wrap) begin
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // A wrap promotes the previous shadow first; a coincident load then refills the shadow.
  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    if (wrap && pend_q) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
    if (bus.load) begin
      shd_d = cfg_in;
      if (bus.en) begin
        pend_d = 1'b1;
      end else begin
        act_d  = cfg_in;
        pend_d = 1'b0;
      end
    end
  end

  // Outputs are derived from the next count and next active set so they line up with cnt.
  always_comb begin
    logic [W-1:0] c1;
    logic [W-1:0] c2;
    mode_e        md;
    logic         raw;
    pwm_d = '0;
    c1    = '0;
    c2    = '0;
    md    = MODE_RSVD;
    raw   = 1'b0;
    for (int unsigned i = 0; i < CH; i++) begin
      c1 = act_d.cmp1[i*W +: W];
      c2 = act_d.cmp2[i*W +: W];
      md = mode_e'(act_d.mode[i*2 +: 2]);
      unique case (md)
        MODE_LEFT:  raw = (c1 != '0) && (cnt_d <= c1);
        MODE_RIGHT: raw = (cnt_d >= c1);
        MODE_WIN:   raw = (c1 < c2) && (cnt_d >= c1) && (cnt_d < c2);
        default:    raw = 1'b0;
      endcase
      pwm_d[i] = (bus.en && act_d.ch_en[i]) ? (raw ^ act_d.pol[i]) : act_d.pol[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_q  <= '0;
      shd_q  <= '0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      pwm_q  <= '0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      pwm_q  <= pwm_d;
    end
  end

  assign bus.cnt          = cnt_q;
  assign bus.period_tick  = tick_q;
  assign bus.load_pending = pend_q;
  assign bus.pwm_out      = pwm_q;

endmodule

// File: tb/tb_pwm_gen_mc.sv
// Directed bench for pwm_gen_mc (CH=4, W=16): hand-sequenced loads and
// period walks, checked with immediate assertions every cycle.
module tb_pwm_gen_mc;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   errors  = 0;

  pwm_gen_mc_if #(.CH(4), .W(16)) bus ();

  pwm_gen_mc #(.CH(4), .W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Values presented on the *_in ports, and the set expected to be active.
  logic [15:0] in_period;
  logic [15:0] in_cmp1 [4];
  logic [15:0] in_cmp2 [4];
  logic [1:0]  in_mode [4];
  logic [3:0]  in_pol, in_chen;
  logic [15:0] ex_cmp1 [4];
  logic [15:0] ex_cmp2 [4];
  logic [1:0]  ex_mode [4];
  logic [3:0]  ex_pol, ex_chen;

  task automatic drive_cfg();
    bus.period_in = in_period;
    for (int c = 0; c < 4; c++) begin
      bus.cmp1_in[c*16 +: 16] = in_cmp1[c];
      bus.cmp2_in[c*16 +: 16] = in_cmp2[c];
      bus.mode_in[c*2 +: 2]   = in_mode[c];
    end
    bus.pol_in   = in_pol;
    bus.ch_en_in = in_chen;
  endtask

  task automatic take_in_as_active();
    for (int c = 0; c < 4; c++) begin
      ex_cmp1[c] = in_cmp1[c];
      ex_cmp2[c] = in_cmp2[c];
      ex_mode[c] = in_mode[c];
    end
    ex_pol  = in_pol;
    ex_chen = in_chen;
  endtask

  function automatic logic [3:0] exp_pwm(input int unsigned n, input logic e);
    logic [3:0] o;
    logic       r;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      case (ex_mode[c])
        2'b00:   r = (ex_cmp1[c] != 0) && (n <= ex_cmp1[c]);
        2'b01:   r = (n >= ex_cmp1[c]);
        2'b10:   r = (ex_cmp1[c] < ex_cmp2[c]) && (n >= ex_cmp1[c]) && (n < ex_cmp2[c]);
        default: r = 1'b0;
      endcase
      o[c] = (e && ex_chen[c]) ? (r ^ ex_pol[c]) : ex_pol[c];
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_cycle(input int unsigned ec, input logic et, input logic el,
                             input logic e);
    chk("cnt", {16'h0, bus.cnt}, ec);
    chk("period_tick", {31'h0, bus.period_tick}, {31'h0, et});
    chk("load_pending", {31'h0, bus.load_pending}, {31'h0, el});
    chk("pwm_out", {28'h0, bus.pwm_out}, {28'h0, exp_pwm(ec, e)});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset with en and load asserted: reset must win.
    in_period = 16'd9;
    for (int c = 0; c < 4; c++) begin
      in_cmp1[c] = '0; in_cmp2[c] = '0; in_mode[c] = '0;
      ex_cmp1[c] = '0; ex_cmp2[c] = '0; ex_mode[c] = '0;
    end
    in_pol = '0; in_chen = '1; ex_pol = '0; ex_chen = '0;
    drive_cfg();
    rst_n = 1'b0; bus.en = 1'b1; bus.load = 1'b1;
    @(negedge clk);
    step(); step();
    check_cycle(0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; bus.en = 1'b0; bus.load = 1'b0;
    step(); step();
    check_cycle(0, 1'b0, 1'b0, 1'b0);

    // Direct load while disabled: ch0 left 3, ch1 right 6, ch2 window 2..5, ch3 pol only.
    in_cmp1[0] = 16'd3; in_mode[0] = 2'b00;
    in_cmp1[1] = 16'd6; in_mode[1] = 2'b01;
    in_cmp1[2] = 16'd2; in_cmp2[2] = 16'd5; in_mode[2] = 2'b10;
    in_pol = 4'b1000; in_chen = 4'b0111;
    drive_cfg(); bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    take_in_as_active();
    check_cycle(0, 1'b0, 1'b0, 1'b0);
    chk("pwm_idle_is_pol", {28'h0, bus.pwm_out}, 32'h8);

    // Two full periods.
    bus.en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check_cycle(k % 10, (k % 10) == 0, 1'b0, 1'b1);
    end

    // Shadowed update at cnt=4: old cmp1 holds until the wrap.
    for (int k = 1; k <= 4; k++) begin step(); check_cycle(k, 1'b0, 1'b0, 1'b1); end
    in_cmp1[0] = 16'd7; drive_cfg(); bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    check_cycle(5, 1'b0, 1'b1, 1'b1);
    for (int k = 6; k <= 9; k++) begin step(); check_cycle(k, 1'b0, 1'b1, 1'b1); end
    step();
    ex_cmp1[0] = 16'd7;
    check_cycle(0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 9; k++) begin step(); check_cycle(k, 1'b0, 1'b0, 1'b1); end

    // Load exactly on the wrap edge: applies one period later.
    in_cmp1[0] = 16'd2; drive_cfg(); bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    check_cycle(0, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 9; k++) begin step(); check_cycle(k, 1'b0, 1'b1, 1'b1); end
    step();
    ex_cmp1[0] = 16'd2;
    check_cycle(0, 1'b1, 1'b0, 1'b1);

    // cmp1=0 in left-align and cmp1==cmp2 in window both give constant 0.
    in_cmp1[0] = 16'd0; in_cmp1[2] = 16'd5; drive_cfg(); bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    check_cycle(1, 1'b0, 1'b1, 1'b1);
    for (int k = 2; k <= 9; k++) begin step(); check_cycle(k, 1'b0, 1'b1, 1'b1); end
    step();
    ex_cmp1[0] = 16'd0; ex_cmp1[2] = 16'd5;
    check_cycle(0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      step();
      check_cycle(k, 1'b0, 1'b0, 1'b1);
      chk("ch0_ch2_const0", {28'h0, bus.pwm_out & 4'b0101}, 32'h0);
    end

    // en dropped at cnt=5 with a load pending; pending survives re-enable.
    step();
    check_cycle(0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin step(); check_cycle(k, 1'b0, 1'b0, 1'b1); end
    in_cmp1[0] = 16'd4; drive_cfg(); bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    check_cycle(5, 1'b0, 1'b1, 1'b1);
    bus.en = 1'b0;
    step();
    check_cycle(0, 1'b0, 1'b1, 1'b0);
    chk("en_off_pwm_pol", {28'h0, bus.pwm_out}, 32'h8);
    step();
    check_cycle(0, 1'b0, 1'b1, 1'b0);
    bus.en = 1'b1;
    step();
    check_cycle(1, 1'b0, 1'b1, 1'b1);
    for (int k = 2; k <= 9; k++) begin step(); check_cycle(k, 1'b0, 1'b1, 1'b1); end
    step();
    ex_cmp1[0] = 16'd4;
    check_cycle(0, 1'b1, 1'b0, 1'b1);

    // period=0: counter pinned at 0, tick held high.
    bus.en = 1'b0; in_period = 16'd0; drive_cfg(); bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    check_cycle(0, 1'b0, 1'b0, 1'b0);
    bus.en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_cycle(0, 1'b1, 1'b0, 1'b1);
      chk("p0_pwm", {28'h0, bus.pwm_out}, 32'h9);
    end

    // period=FFFF: full-range count, wrap without overflow.
    bus.en = 1'b0; in_period = 16'hFFFF; drive_cfg(); bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    check_cycle(0, 1'b0, 1'b0, 1'b0);
    bus.en = 1'b1;
    for (int k = 0; k < 65534; k++) step();
    check_cycle(16'hFFFE, 1'b0, 1'b0, 1'b1);
    step();
    check_cycle(16'hFFFF, 1'b0, 1'b0, 1'b1);
    step();
    check_cycle(0, 1'b1, 1'b0, 1'b1);

    // Reset mid-operation overrides en and load.
    for (int k = 0; k < 5; k++) step();
    rst_n = 1'b0; bus.load = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin ex_cmp1[c] = '0; ex_cmp2[c] = '0; ex_mode[c] = '0; end
    ex_pol = '0; ex_chen = '0;
    check_cycle(0, 1'b0, 1'b0, 1'b0);
    chk("rst_pwm_zero", {28'h0, bus.pwm_out}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
